// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the carry-save adder operand loader.
package csa_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int NUM_OPS = 4;
    localparam int CNT_W   = $clog2(NUM_OPS);

    // Four W-bit operands sum to at most 4*(2^W-1), which always fits in W+2 bits.
    function automatic int ref_width(input int w);
        return w + 2;
    endfunction

endpackage

// File: rtl/csa_operand_loader.sv
// Packs four operand beats into one (a,b,c,d) group with a running golden sum.
// Optional macro CSA_LOADER_FLUSH_EN adds a flush input that presents a partial group.
module csa_operand_loader
    import csa_pkg::*;
#(
    parameter int W = 4
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            out_a,
    output logic [W-1:0]            out_b,
    output logic [W-1:0]            out_c,
    output logic [W-1:0]            out_d,
    output logic [ref_width(W)-1:0] out_ref
`ifdef CSA_LOADER_FLUSH_EN
    ,
    input  logic                    flush
`endif
);

    localparam int RW = ref_width(W);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     slot_q [NUM_OPS];
    logic [W-1:0]     slot_d [NUM_OPS];
    logic [RW-1:0]    ref_q, ref_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             accept;
    logic             flush_req;

    assign accept = in_valid && in_ready_q;

`ifdef CSA_LOADER_FLUSH_EN
    // A flush only makes sense if at least one slot ends up filled this cycle.
    assign flush_req = flush && (state_q == FILL) && ((cnt_q != '0) || accept);
`else
    assign flush_req = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ref_d   = ref_q;
        for (int i = 0; i < NUM_OPS; i++) begin
            slot_d[i] = slot_q[i];
        end

        if (state_q == FILL) begin
            if (accept) begin
                slot_d[cnt_q] = in_data;
                cnt_d         = cnt_q + CNT_W'(1);
                ref_d         = ref_q + RW'(in_data);
                if (cnt_q == CNT_W'(NUM_OPS - 1)) begin
                    state_d = HOLD;
                end
            end
            if (flush_req) begin
                state_d = HOLD;
            end
        end else begin
            if (out_valid_q && out_ready) begin
                state_d = FILL;
                cnt_d   = '0;
                ref_d   = '0;
                for (int i = 0; i < NUM_OPS; i++) begin
                    slot_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            ref_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NUM_OPS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ref_q       <= ref_d;
            // Handshake flags are registered copies of the next state, so they
            // switch on the same edge as the state itself.
            in_ready_q  <= (state_d == FILL);
            out_valid_q <= (state_d == HOLD);
            for (int i = 0; i < NUM_OPS; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_a     = slot_q[0];
    assign out_b     = slot_q[1];
    assign out_c     = slot_q[2];
    assign out_d     = slot_q[3];
    assign out_ref   = ref_q;

endmodule

// File: tb/tb_csa_operand_loader.sv
// Directed plus randomized bench for csa_operand_loader against a queue-based group model.
module tb_csa_operand_loader;

    localparam int W = 4;
`ifdef CSA_LOADER_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_a, out_b, out_c, out_d;
    logic [W+1:0] out_ref;
    logic         flush;

    csa_operand_loader #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_c    (out_c),
        .out_d    (out_d),
        .out_ref  (out_ref)
`ifdef CSA_LOADER_FLUSH_EN
        ,
        .flush    (flush)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: operands of the group currently being built or presented.
    int cur[$];
    bit hold_m = 1'b0;
    bit rdy_m  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit v, input int d, input bit r, input bit f);
        int sum;
        int slot;
        logic [W-1:0] obs_slot;
        @(negedge clk);
        rst_n     = rst;
        in_valid  = v;
        in_data   = d[W-1:0];
        out_ready = r;
        flush     = f;
        @(posedge clk);
        if (!rst) begin
            cur.delete();
            hold_m = 1'b0;
            rdy_m  = 1'b0;
        end else if (hold_m) begin
            if (r) begin
                cur.delete();
                hold_m = 1'b0;
                rdy_m  = 1'b1;
            end
        end else begin
            if (v && rdy_m) cur.push_back(d & 15);
            if (cur.size() == 4 || (FLUSH_EN && f && cur.size() > 0)) begin
                hold_m = 1'b1;
                rdy_m  = 1'b0;
            end else begin
                rdy_m = 1'b1;
            end
        end
        #1;
        sum = 0;
        foreach (cur[i]) sum += cur[i];
        chk("in_ready", 32'(in_ready), 32'(rdy_m));
        chk("out_valid", 32'(out_valid), 32'(hold_m));
        for (int i = 0; i < 4; i++) begin
            slot = (i < cur.size()) ? cur[i] : 0;
            case (i)
                0: obs_slot = out_a;
                1: obs_slot = out_b;
                2: obs_slot = out_c;
                default: obs_slot = out_d;
            endcase
            chk($sformatf("slot%0d", i), 32'(obs_slot), 32'(slot));
        end
        chk("out_ref", 32'(out_ref), 32'(sum));
        $display("step rst_n=%0b v=%0b d=%0d rdy=%0b fl=%0b -> in_ready=%0b out_valid=%0b a=%0d b=%0d c=%0d d=%0d ref=%0d",
                 rst, v, d, r, f, in_ready, out_valid, out_a, out_b, out_c, out_d, out_ref);
    endtask

    task automatic beat(input int d, input bit r);
        step(1'b1, 1'b1, d, r, 1'b0);
    endtask

    task automatic idle(input bit r);
        step(1'b1, 1'b0, 0, r, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        step(1'b0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5, 1'b1, 1'b0);
        chk("reset_ready", 32'(in_ready), 32'd0);
        idle(1'b0);
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        // Group 10,0,0,0
        beat(10, 1); beat(0, 1); beat(0, 1); beat(0, 1);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_ref", 32'(out_ref), 32'd10);
        idle(1'b1);
        chk("t1_ready_back", 32'(in_ready), 32'd1);

        // Maximum operands
        beat(15, 1); beat(15, 1); beat(15, 1); beat(15, 1);
        chk("t2_ref", 32'(out_ref), 32'd60);
        idle(1'b1);

        // Backpressure with a pending beat
        beat(4, 0); beat(6, 0); beat(12, 0); beat(0, 0);
        for (int i = 0; i < 5; i++) beat(9, 0);
        chk("t3_held_ref", 32'(out_ref), 32'd22);
        chk("t3_held_ready", 32'(in_ready), 32'd0);
        beat(9, 1);
        beat(9, 1);
        chk("t3_next_a", 32'(out_a), 32'd9);
        beat(1, 1); beat(2, 1); beat(3, 1);
        idle(1'b1);

        // Reset mid-group
        beat(11, 1); beat(2, 1);
        step(1'b0, 1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1, 1'b0);
        idle(1'b1);
        beat(11, 1); beat(2, 1); beat(4, 1); beat(7, 1);
        chk("t4_ref", 32'(out_ref), 32'd24);
        chk("t4_d", 32'(out_d), 32'd7);
        idle(1'b1);

        // Gaps in in_valid
        beat(12, 1); idle(1'b1); idle(1'b1); beat(5, 1); idle(1'b1); beat(10, 1); beat(10, 1);
        chk("t5_ref", 32'(out_ref), 32'd37);
        idle(1'b1);

        if (FLUSH_EN) begin
            beat(4, 1); beat(6, 1);
            step(1'b1, 1'b0, 0, 1'b1, 1'b1);
            chk("t6_flush_ref", 32'(out_ref), 32'd10);
            idle(1'b1);
            step(1'b1, 1'b1, 7, 1'b1, 1'b1);
            chk("t6_beat_flush_a", 32'(out_a), 32'd7);
            idle(1'b1);
            step(1'b1, 1'b0, 0, 1'b1, 1'b1);
            chk("t6_empty_flush", 32'(out_valid), 32'd0);
        end

        for (int n = 0; n < 400; n++) begin
            step(($urandom % 50) != 0, $urandom % 2 == 0, int'($urandom % 16),
                 ($urandom % 5) < 3, ($urandom % 6) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/csa_operand_loader.md
Name: csa_operand_loader

Overview:
Upstream feeder for the 4-operand, 4-bit carry-save adder stage. Accepts operands one per beat over a valid/ready stream and packs every four beats into one group (a, b, c, d). Presents each group as parallel registered operands with a valid/ready handshake to the adder. Also carries an incrementally built golden sum for downstream checking.

Parameters:
W, 4, operand width in bits; the golden sum is W+2 bits wide.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  in_data holds a valid operand
in_ready  output  1  loader accepts a beat this cycle
in_data  input  W  operand beat
out_valid  output  1  a group is presented on out_a..out_d
out_ready  input  1  downstream consumes the group this cycle
out_a  output  W  group operand 0 (first beat)
out_b  output  W  group operand 1
out_c  output  W  group operand 2
out_d  output  W  group operand 3 (fourth beat)
out_ref  output  W+2  a+b+c+d of the presented group, unsigned
flush  input  1  present a partial group (only exists with CSA_LOADER_FLUSH_EN)

Behaviour:
- One clock. Reset is synchronous and active-low: it takes effect on the clk edge while rst_n=0.
- All outputs are registered. Reset values: in_ready=0, out_valid=0, out_a..out_d=0, out_ref=0. Reset also sets state=FILL and cnt=0.
- in_ready rises on the first edge after rst_n is released.
- States: FILL and HOLD.
- FILL:
  - in_ready=1 and out_valid=0.
  - A beat is accepted when in_valid && in_ready.
  - An accepted beat is written to slot[cnt] (cnt 0→a, 1→b, 2→c, 3→d). cnt increments and out_ref += in_data, zero-extended to W+2.
  - Gaps in in_valid are allowed; cnt holds across them.
- FILL→HOLD: taken on the edge that accepts the fourth beat (cnt=3). out_valid=1 and in_ready=0 on the next cycle, so latency is 1 cycle from the last beat to out_valid.
- HOLD:
  - out_a..out_d and out_ref are stable while out_valid=1 && out_ready=0. Backpressure is unbounded.
  - in_valid is ignored; no beat is accepted or lost.
- HOLD→FILL: on out_valid && out_ready. On the next cycle out_valid=0, in_ready=1, cnt=0, slots=0 and out_ref=0.
- There is no same-cycle overlap, so peak throughput is one group per 5 cycles.
- Width rule: out_ref cannot overflow, since max 4×(2^W−1) < 2^(W+2). For W=4 the maximum is 60.
- Reset mid-group or in HOLD drops the partial or presented group entirely. No stale slot value appears in the next group.
- out_ready while out_valid=0 has no effect.

Optional Feature:
Macro CSA_LOADER_FLUSH_EN.
- Defined: the flush port exists and is sampled only in FILL.
  - flush=1 with cnt≥1 forces FILL→HOLD. Unfilled slots present as 0 and out_ref covers the filled slots only.
  - If a beat is accepted in the same cycle as flush, the beat is stored first, then the group is presented.
  - flush=1 with cnt=0 and no beat accepted is ignored.
  - flush is ignored in HOLD.
- Undefined: the port is absent and groups are always exactly four beats.

Decomposition:
- Package csa_pkg:
  - state enum {FILL, HOLD}
  - localparam NUM_OPS=4
  - cnt width $clog2(NUM_OPS)
  - a function giving the golden-sum width W+2
- No sub-module. The slot array, counter, accumulator and FSM sit in one module.

Test Plan:
1. Beats 10,0,0,0 back-to-back with out_ready=1 → out_valid one cycle after the 4th beat, a=10, b=c=d=0, out_ref=10; then in_ready=1 on the next cycle.
2. Beats 15,15,15,15 → a=b=c=d=15, out_ref=60 (no overflow).
3. Beats 4,6,12,0, then out_ready=0 for 5 cycles while in_valid=1 with data 9 → outputs held, in_ready=0, the 9 is not accepted; after out_ready=1 the next group starts with the 9.
4. Beats 11,2 then rst_n=0 for 2 cycles, then beats 11,2,4,7 → only one group appears: a=11, b=2, c=4, d=7, out_ref=24.
5. Beats with in_valid gaps (on, off, off, on, off, on, on) carrying 12,5,10,10 → a=12, b=5, c=10, d=10, out_ref=37.
6. CSA_LOADER_FLUSH_EN: beats 4,6, then flush → a=4, b=6, c=0, d=0, out_ref=10. Beat 7 accepted together with flush at cnt=0 → a=7, others 0, out_ref=7. flush alone at cnt=0 → no group produced.
